// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the pipeline back end.
package riscv_pkg;

  // Writeback source select; 2'b11 aliases the ALU result.
  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_LOAD    = 2'b01;
  localparam logic [1:0] WB_PC4     = 2'b10;
  localparam logic [1:0] WB_ALU_ALT = 2'b11;

  // Load width/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/dff.sv
// Enabled D flip-flop bank with asynchronous active-low reset to a constant.
module dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when enabled; reset forces the constant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/load_align.sv
// Extracts and extends load data from a word-aligned memory read and flags
// misaligned or unsupported load encodings. Purely combinational.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        fault
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte and half-word lanes.
  always_comb begin
    byte_lane = rdata[7:0];
    case (off)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend per width/sign and flag misalignment or reserved encodings.
  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU: data = {24'd0, byte_lane};
      F3_LH: begin
        data  = {{16{half_lane[15]}}, half_lane};
        fault = off[0];
      end
      F3_LHU: begin
        data  = {16'd0, half_lane};
        fault = off[0];
      end
      F3_LW: begin
        data  = rdata;
        fault = (off != 2'd0);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: WB pipeline register, load formatting, register-file
// write port, load fault reporting and the retired-instruction counter.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [4:0]      i_rd_addr,
  input  logic [1:0]      i_wb_sel,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_dmem_rdata,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic [4:0]      o_rd_waddr,
  output logic [XLEN-1:0] o_rd_wdata,
  output logic            o_retire,
  output logic            o_trap,
  output logic [XLEN-1:0] o_badaddr,
  output logic [63:0]     o_instret
);

  localparam int FIELD_W = 5 + 2 + 3 + 3 * XLEN;

  logic               wb_valid;
  logic [4:0]         wb_rd;
  logic [1:0]         wb_sel;
  logic [2:0]         wb_funct3;
  logic [XLEN-1:0]    wb_alu;
  logic [XLEN-1:0]    wb_pc4;
  logic [XLEN-1:0]    wb_rdata;
  logic [FIELD_W-1:0] wb_fields;

  logic [XLEN-1:0]    load_data;
  logic               load_fault;
  logic               presented;
  logic               fault;
  logic               retire;
  logic [XLEN-1:0]    wb_src;

  // Flush clears valid even under stall; payload fields simply hold on stall
  // since a cleared valid masks them anyway.
  dff #(.WIDTH(1)) u_valid_q (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (i_flush | ~i_stall),
    .d     (i_valid & ~i_flush),
    .q     (wb_valid)
  );

  dff #(.WIDTH(FIELD_W)) u_fields_q (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (~i_stall),
    .d     ({i_rd_addr, i_wb_sel, i_funct3, i_alu_result, i_pc_plus4, i_dmem_rdata}),
    .q     (wb_fields)
  );

  assign {wb_rd, wb_sel, wb_funct3, wb_alu, wb_pc4, wb_rdata} = wb_fields;

  load_align u_load_align (
    .funct3 (wb_funct3),
    .off    (wb_alu[1:0]),
    .rdata  (wb_rdata),
    .data   (load_data),
    .fault  (load_fault)
  );

  // Writeback source mux and commit/trap qualification.
  always_comb begin
    case (wb_sel)
      WB_LOAD: wb_src = load_data;
      WB_PC4:  wb_src = wb_pc4;
      default: wb_src = wb_alu;
    endcase
    presented = wb_valid & ~i_stall;
    fault     = (wb_sel == WB_LOAD) & load_fault;
    retire    = presented & ~fault;
  end

  // Drive the register-file port and trap outputs; x0 targets retire silently.
  always_comb begin
    o_rd_waddr = '0;
    o_rd_wdata = '0;
    o_retire   = 1'b0;
    o_trap     = 1'b0;
    o_badaddr  = '0;
    if (retire) begin
      o_rd_waddr = wb_rd;
      o_rd_wdata = wb_src;
      o_retire   = 1'b1;
    end else if (presented) begin
      o_trap    = 1'b1;
      o_badaddr = wb_alu;
    end
  end

  // Counter wraps naturally at 2^64.
  dff #(.WIDTH(64)) u_instret_q (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (retire),
    .d     (o_instret + 64'd1),
    .q     (o_instret)
  );

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import riscv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [4:0]  i_rd_addr;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_result;
  logic [31:0] i_pc_plus4;
  logic [2:0]  i_funct3;
  logic [31:0] i_dmem_rdata;
  logic        i_stall;
  logic        i_flush;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;
  logic        o_retire;
  logic        o_trap;
  logic [31:0] o_badaddr;
  logic [63:0] o_instret;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state: the instruction sitting in writeback plus the counter.
  bit          m_valid;
  int unsigned m_rd, m_sel, m_f3, m_alu, m_pc4, m_rdata;
  longint unsigned m_instret;

  wb_stage #(.XLEN(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_rd_addr    (i_rd_addr),
    .i_wb_sel     (i_wb_sel),
    .i_alu_result (i_alu_result),
    .i_pc_plus4   (i_pc_plus4),
    .i_funct3     (i_funct3),
    .i_dmem_rdata (i_dmem_rdata),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .o_rd_waddr   (o_rd_waddr),
    .o_rd_wdata   (o_rd_wdata),
    .o_retire     (o_retire),
    .o_trap       (o_trap),
    .o_badaddr    (o_badaddr),
    .o_instret    (o_instret)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
    m_alu = 0; m_pc4 = 0; m_rdata = 0; m_instret = 0;
  endtask

  // Expected port values from the held instruction and the current stall input.
  task automatic model_eval(output int unsigned waddr, output int unsigned wdata,
                            output bit retire, output bit trap, output int unsigned badaddr);
    int unsigned off, b, h, ld, src;
    bit bad, present;
    off = m_alu % 4;
    b   = (m_rdata >> (8 * off)) % 256;
    h   = (m_rdata >> (16 * (off / 2))) % 65536;
    ld  = 0;
    bad = 0;
    case (m_f3)
      0: ld = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: ld = b;
      1: begin ld = (h >= 32768) ? h + 32'hFFFF_0000 : h; bad = (off % 2) != 0; end
      5: begin ld = h; bad = (off % 2) != 0; end
      2: begin ld = m_rdata; bad = off != 0; end
      default: bad = 1;
    endcase
    if (m_sel == 1) src = ld;
    else if (m_sel == 2) src = m_pc4;
    else src = m_alu;
    if (m_sel != 1) bad = 0;
    present = m_valid && !i_stall;
    retire  = present && !bad;
    trap    = present && bad;
    waddr   = retire ? m_rd : 0;
    wdata   = retire ? src : 0;
    badaddr = trap ? m_alu : 0;
  endtask

  task automatic check_model();
    int unsigned wa, wd, ba;
    bit rt, tp;
    model_eval(wa, wd, rt, tp, ba);
    check("waddr",   64'(o_rd_waddr), 64'(wa));
    check("wdata",   64'(o_rd_wdata), 64'(wd));
    check("retire",  64'(o_retire),   64'(rt));
    check("trap",    64'(o_trap),     64'(tp));
    check("badaddr", 64'(o_badaddr),  64'(ba));
    check("instret", o_instret,       m_instret);
  endtask

  task automatic clock_edge();
    int unsigned wa, wd, ba;
    bit rt, tp;
    @(posedge i_clk);
    model_eval(wa, wd, rt, tp, ba);
    if (rt) m_instret++;
    if (i_flush) m_valid = 0;
    else if (!i_stall) m_valid = i_valid;
    if (!i_stall) begin
      m_rd = i_rd_addr; m_sel = i_wb_sel; m_f3 = i_funct3;
      m_alu = i_alu_result; m_pc4 = i_pc_plus4; m_rdata = i_dmem_rdata;
    end
    @(negedge i_clk);
  endtask

  task automatic drive(input bit v, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                       input logic [31:0] rdata, input bit stall, input bit flush);
    i_valid = v; i_rd_addr = rd; i_wb_sel = sel; i_alu_result = alu;
    i_pc_plus4 = pc4; i_funct3 = f3; i_dmem_rdata = rdata;
    i_stall = stall; i_flush = flush;
  endtask

  task automatic idle(input bit stall);
    drive(0, 5'd0, WB_ALU, 32'd0, 32'd0, 3'd0, 32'd0, stall, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_waddr"},   64'(o_rd_waddr), 64'd0);
    check({tag, "_wdata"},   64'(o_rd_wdata), 64'd0);
    check({tag, "_retire"},  64'(o_retire),   64'd0);
    check({tag, "_trap"},    64'(o_trap),     64'd0);
    check({tag, "_badaddr"}, 64'(o_badaddr),  64'd0);
    check({tag, "_instret"}, o_instret,       64'd0);
  endtask

  initial begin
    i_rst_n = 0;
    idle(0);
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1;
    #1;
    check_all_zero("post_reset");

    // LB then LBU of the same byte
    drive(1, 5'd5, WB_LOAD, 32'h1003, 32'h0, F3_LB, 32'h80AA55CC, 0, 0);
    clock_edge();
    drive(1, 5'd5, WB_LOAD, 32'h1003, 32'h0, F3_LBU, 32'h80AA55CC, 0, 0);
    #1;
    check("lb_waddr",  64'(o_rd_waddr), 64'd5);
    check("lb_wdata",  64'(o_rd_wdata), 64'hFFFF_FF80);
    check("lb_retire", 64'(o_retire),   64'd1);
    check_model();
    clock_edge();
    drive(1, 5'd9, WB_LOAD, 32'h2001, 32'h0, F3_LH, 32'h1234_5678, 0, 0);
    #1;
    check("lbu_wdata", 64'(o_rd_wdata), 64'h0000_0080);
    check_model();
    clock_edge();

    // misaligned LH traps without retiring
    idle(0);
    #1;
    check("lh_trap",    64'(o_trap),     64'd1);
    check("lh_badaddr", 64'(o_badaddr),  64'h2001);
    check("lh_waddr",   64'(o_rd_waddr), 64'd0);
    check("lh_instret", o_instret,       64'd2);
    clock_edge();
    #1;
    check("lh_instret_after", o_instret, 64'd2);

    // JAL held by a 3-cycle stall
    drive(1, 5'd1, WB_PC4, 32'h55, 32'h104, 3'd0, 32'h0, 0, 0);
    clock_edge();
    for (int k = 0; k < 3; k++) begin
      idle(1);
      #1;
      check("jal_stall_waddr",  64'(o_rd_waddr), 64'd0);
      check("jal_stall_retire", 64'(o_retire),   64'd0);
      check_model();
      clock_edge();
    end
    idle(0);
    #1;
    check("jal_waddr", 64'(o_rd_waddr), 64'd1);
    check("jal_wdata", 64'(o_rd_wdata), 64'h104);
    clock_edge();
    #1;
    check("jal_instret", o_instret, 64'd3);
    check("jal_once",    64'(o_retire), 64'd0);

    // back-to-back ALU ops to x0 and x7
    drive(1, 5'd0, WB_ALU, 32'h1234, 32'h0, 3'd0, 32'h0, 0, 0);
    clock_edge();
    drive(1, 5'd7, WB_ALU, 32'hDEADBEEF, 32'h0, 3'd0, 32'h0, 0, 0);
    #1;
    check("x0_waddr",  64'(o_rd_waddr), 64'd0);
    check("x0_retire", 64'(o_retire),   64'd1);
    clock_edge();
    idle(0);
    #1;
    check("x7_waddr", 64'(o_rd_waddr), 64'd7);
    check("x7_wdata", 64'(o_rd_wdata), 64'hDEADBEEF);
    clock_edge();
    #1;
    check("alu_instret", o_instret, 64'd5);

    // flush at capture: the op never writes
    drive(1, 5'd3, WB_ALU, 32'h33, 32'h0, 3'd0, 32'h0, 0, 1);
    clock_edge();
    drive(1, 5'd4, WB_ALU, 32'h44, 32'h0, 3'd0, 32'h0, 0, 0);
    #1;
    check("flush_waddr",  64'(o_rd_waddr), 64'd0);
    check("flush_retire", 64'(o_retire),   64'd0);
    clock_edge();
    // flush in the same cycle as a presentation
    drive(1, 5'd6, WB_ALU, 32'h66, 32'h0, 3'd0, 32'h0, 0, 1);
    #1;
    check("flush_pres_waddr", 64'(o_rd_waddr), 64'd4);
    check("flush_pres_wdata", 64'(o_rd_wdata), 64'h44);
    clock_edge();
    idle(0);
    #1;
    check("flush_bubble", 64'(o_retire), 64'd0);
    check_model();
    clock_edge();

    // asynchronous reset while an op is held by stall
    drive(1, 5'd8, WB_ALU, 32'h88, 32'h0, 3'd0, 32'h0, 0, 0);
    clock_edge();
    idle(1);
    #2;
    i_rst_n = 0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(negedge i_clk);
    i_rst_n = 1;
    idle(0);
    #1;
    check("rst_discard_waddr",  64'(o_rd_waddr), 64'd0);
    check("rst_discard_retire", 64'(o_retire),   64'd0);
    clock_edge();

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, 5'($urandom), 2'($urandom), $urandom, $urandom,
            3'($urandom), $urandom, ($urandom % 5) == 0, ($urandom % 8) == 0);
      #1;
      check_model();
      clock_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
